// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes and FSM states.
package hilo_pkg;

  localparam logic [2:0] OP_MTHI  = 3'd0;
  localparam logic [2:0] OP_MTLO  = 3'd1;
  localparam logic [2:0] OP_MULT  = 3'd2;
  localparam logic [2:0] OP_MULTU = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/div_core.sv
// Unsigned restoring divider datapath: one shift-subtract step per enabled cycle.
module div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Partial remainder is always < divisor, so the shifted value fits in WIDTH+1 bits.
  always_comb begin
    shifted = {rem_q, quot_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, div_q};
    rem_d   = rem_q;
    quot_d  = quot_q;
    div_d   = div_q;
    if (load) begin
      rem_d  = '0;
      quot_d = dividend_i;
      div_d  = divisor_i;
    end else if (en) begin
      rem_d  = diff[WIDTH+1] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      quot_d = {quot_q[WIDTH-2:0], ~diff[WIDTH+1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      div_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      div_q  <= div_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO unit: MTHI/MTLO, single-cycle MULT/MULTU, iterative cancellable DIV/DIVU.
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             negq_q, negq_d, negr_q, negr_d;

  logic             accept, is_div, div_load, sgn_mul, sgn_div;
  logic [WIDTH-1:0] mag_a, mag_b, quot, rem, q_fix, r_fix;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;

  assign accept   = start && (state_q == IDLE) && !cancel && (op <= OP_DIVU);
  assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
  assign div_load = accept && is_div && (src_b != '0);
  assign sgn_mul  = (op == OP_MULT);
  assign sgn_div  = (op == OP_DIV);

  // Sign-extending both operands to 2*WIDTH makes one truncated multiply serve both signednesses.
  assign ext_a = {{WIDTH{sgn_mul & src_a[WIDTH-1]}}, src_a};
  assign ext_b = {{WIDTH{sgn_mul & src_b[WIDTH-1]}}, src_b};
  assign prod  = ext_a * ext_b;

  assign mag_a = (sgn_div && src_a[WIDTH-1]) ? (~src_a + 1'b1) : src_a;
  assign mag_b = (sgn_div && src_b[WIDTH-1]) ? (~src_b + 1'b1) : src_b;

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk        (clk),
    .rst        (rst),
    .load       (div_load),
    .en         (state_q == RUN),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .quot_o     (quot),
    .rem_o      (rem)
  );

  assign q_fix = negq_q ? (~quot + 1'b1) : quot;
  assign r_fix = negr_q ? (~rem + 1'b1) : rem;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    negq_d  = negq_q;
    negr_d  = negr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          done_d = !div_load;
          case (op)
            OP_MTHI:            hi_d = src_a;
            OP_MTLO:            lo_d = src_a;
            OP_MULT, OP_MULTU:  {hi_d, lo_d} = prod;
            default: begin
              if (src_b == '0) begin
                hi_d = src_a;
                lo_d = '1;
              end else begin
                state_d = RUN;
                cnt_d   = CW'(WIDTH);
                negq_d  = sgn_div && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                negr_d  = sgn_div && src_a[WIDTH-1];
              end
            end
          endcase
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        cnt_d   = '0;
        if (!cancel) begin
          hi_d   = r_fix;
          lo_d   = q_fix;
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv against an arithmetic reference model.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst, start, cancel, busy, done;
  logic [2:0]  op;
  logic [31:0] src_a, src_b, hi_o, lo_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural result of one accepted op, from plain 64-bit arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      3'd0: exp_hi = a;
      3'd1: exp_lo = a;
      3'd2: begin q = sa * sb; exp_hi = q[63:32]; exp_lo = q[31:0]; end
      3'd3: begin p = ua * ub; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd4, 3'd5: begin
        if (b == 0) begin
          exp_hi = a;
          exp_lo = '1;
        end else if (o == 3'd4) begin
          q = sa / sb;
          r = sa % sb;
          exp_lo = q[31:0];
          exp_hi = r[31:0];
        end else begin
          p = ua / ub;
          exp_lo = p[31:0];
          p = ua % ub;
          exp_hi = p[31:0];
        end
      end
      default: ;
    endcase
  endtask

  // Issue one op; optional cancel/reset/intruding-start at divide cycle N (0 = none).
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int cancel_at, input int rst_at, input int poke_at);
    int n;
    bit is_run, aborted;
    n = 0;
    aborted = 0;
    is_run = ((o == 3'd4) || (o == 3'd5)) && (b != 0);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
    if (!is_run) begin
      model(o, a, b);
      chk("single_busy", busy, 0);
      chk("single_done", done, (o <= 3'd5) ? 1 : 0);
      chk("single_hi", hi_o, exp_hi);
      chk("single_lo", lo_o, exp_lo);
      return;
    end
    chk("div_busy_rise", busy, 1);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
      if (n == cancel_at) cancel = 1'b1;
      if (n == rst_at) rst = 1'b1;
      if (n == poke_at) begin
        start = 1'b1; op = 3'd0; src_a = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0; rst = 1'b0;
      if (n == cancel_at || n == rst_at) begin
        aborted = 1;
        break;
      end
    end
    if (n == rst_at) begin
      exp_hi = '0;
      exp_lo = '0;
    end else if (!aborted) begin
      model(o, a, b);
      chk("div_busy_cycles", n, 33);
    end
    chk("div_done", done, aborted ? 0 : 1);
    chk("div_busy_end", busy, 0);
    chk("div_hi", hi_o, exp_hi);
    chk("div_lo", lo_o, exp_lo);
  endtask

  task automatic chk_quiet(input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, done, 0);
    chk({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    do_op(3'd0, 32'h1234_5678, 32'h0, 0, 0, 0);
    do_op(3'd1, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
    chk("mt_hi_const", hi_o, 32'h1234_5678);
    chk("mt_lo_const", lo_o, 32'hDEAD_BEEF);
    chk_quiet("mt");

    do_op(3'd2, 32'hFFFF_FFFE, 32'h3, 0, 0, 0);
    chk("mult_hi_const", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo_const", lo_o, 32'hFFFF_FFFA);
    do_op(3'd3, 32'hFFFF_FFFE, 32'h3, 0, 0, 0);
    chk("multu_hi_const", hi_o, 32'h2);
    chk("multu_lo_const", lo_o, 32'hFFFF_FFFA);
    chk_quiet("mul");

    do_op(3'd4, 32'hFFFF_FFF9, 32'h2, 0, 0, 0);
    chk("div_lo_const", lo_o, 32'hFFFF_FFFD);
    chk("div_hi_const", hi_o, 32'hFFFF_FFFF);
    do_op(3'd5, 32'd100, 32'd7, 0, 0, 0);
    chk("divu_lo_const", lo_o, 32'd14);
    chk("divu_hi_const", hi_o, 32'd2);
    chk_quiet("div");

    do_op(3'd5, 32'd5, 32'd0, 0, 0, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    chk("ovf_lo_const", lo_o, 32'h8000_0000);
    chk("ovf_hi_const", hi_o, 32'h0);

    do_op(3'd4, 32'd1000, 32'd3, 10, 0, 0);
    chk_quiet("cancel");
    do_op(3'd4, 32'd1000, 32'd3, 33, 0, 0);
    do_op(3'd4, 32'd999, 32'd4, 0, 10, 0);

    // Start blocked by cancel while idle.
    do_op(3'd0, 32'hCAFE_0001, 32'h0, 0, 0, 0);
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 3'd1; src_a = 32'h5555_AAAA;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    chk("cancel_idle_done", done, 0);
    chk("cancel_idle_lo", lo_o, exp_lo);

    do_op(3'd6, 32'h1, 32'h2, 0, 0, 0);

    do_op(3'd4, $urandom, 32'd13, 0, 0, 5);
    do_op(3'd5, $urandom, $urandom, 0, 0, 0);
    do_op(3'd2, $urandom, $urandom, 0, 0, 0);
    do_op(3'd4, $urandom, $urandom, 0, 0, 0);
    chk_quiet("b2b");

    for (int i = 0; i < 12; i++) begin
      logic [2:0] ro;
      logic [31:0] ra, rb;
      ro = 3'(2 + $urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom >> $urandom_range(0, 31));
      do_op(ro, ra, rb, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Parametrised HI/LO unit for the EX stage of the integer pipeline. It holds the HI/LO architectural registers and executes MTHI, MTLO, single-cycle MULT/MULTU, and iterative DIV/DIVU. While a divide runs it raises `busy` so the pipeline stalls, and it supports cancellation when an older instruction flushes the pipe.

## Interface
Parameters:
- `WIDTH`, default 32: data width of operands, HI and LO.

Ports:
- `clk`, input, 1: clock; all state changes on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: request a new operation; accepted only when `busy`=0.
- `op`, input, 3: operation code, sampled with `start`.
  - 0 = MTHI
  - 1 = MTLO
  - 2 = MULT
  - 3 = MULTU
  - 4 = DIV
  - 5 = DIVU
  - 6 and 7 = no-op.
- `src_a`, input, WIDTH: rs operand (dividend / multiplicand / move source).
- `src_b`, input, WIDTH: rt operand (divisor / multiplier).
- `cancel`, input, 1: abort the in-flight divide; also blocks acceptance of `start` in the same cycle.
- `busy`, output, 1: divide in progress; stall request to the pipeline.
- `done`, output, 1: one-cycle pulse; the HI/LO write from the last accepted op is now visible.
- `hi_o`, output, WIDTH: current HI.
- `lo_o`, output, WIDTH: current LO.

## Operation
- **Reset:** `hi_o`=0, `lo_o`=0, `busy`=0, `done`=0, FSM=IDLE, iteration counter=0. Reset has priority over everything, including mid-divide.
- **Accept condition:** `start`=1, `busy`=0, `cancel`=0, `op`≤5. If `start` is high while `busy`=1, it is ignored (no queueing).
- **MTHI:** HI←`src_a`, LO unchanged.
- **MTLO:** LO←`src_a`, HI unchanged.
- **MULT:** {HI,LO}←signed(`src_a`)×signed(`src_b`), full 2·WIDTH-bit product.
- **MULTU:** same as MULT, unsigned.
- **DIV/DIVU:** LO←quotient, HI←remainder.
  - Signed: operate on magnitudes. Quotient is negated when the operand signs differ. Remainder takes the sign of the dividend.
  - Divisor = 0: no iteration. Completes like a MULT (no busy) with HI←`src_a`, LO←all ones.
  - Signed −2^(W−1) / −1: LO=0x8000_0000 and HI=0 (for W=32); this falls out of the magnitude algorithm.
- **FSM states:**
  - IDLE: on accepted DIV/DIVU with nonzero divisor, latch operand magnitudes and sign flags, load counter=WIDTH, go to RUN.
  - RUN: one restoring shift-subtract step per cycle, counter decrements. When counter reaches 1 and its step is done, go to FIX.
  - FIX: apply sign correction, write HI/LO, go to IDLE.
- **Cancel:** `cancel`=1 in RUN or FIX means next edge goes to IDLE. No HI/LO write, no `done`.
- **Status outputs:** `busy` = (state≠IDLE). `done` is registered.

## Timing
- Edge E0 accepts `start`.
- **MTHI/MTLO/MULT/MULTU/div-by-zero:** HI/LO update at E0. `done`=1 during the cycle after E0. `busy` never asserts.
- **DIV/DIVU:**
  - `busy`=1 from after E0 through E(WIDTH+1), i.e. WIDTH+1 cycles.
  - RUN spans E1..E_WIDTH; FIX writes at E(WIDTH+1).
  - After E(WIDTH+1): `busy`=0, `done`=1, and new HI/LO visible in the same cycle.
- A new `start` is accepted in the cycle `done` is high (back-to-back issue).
- Cancel in the same cycle as the FIX edge: cancel wins, HI/LO keep their old values.
- `hi_o`/`lo_o` are registered and never show partial divide results.

## Structure
- Package `hilo_pkg` holds:
  - op encoding localparams: `OP_MTHI`, `OP_MTLO`, `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`;
  - FSM state encoding: IDLE, RUN, FIX.
- Sub-module `div_core`: unsigned restoring divider datapath (partial remainder and quotient shift registers, one step per enable, parametrised by WIDTH).
- The top level holds the FSM, sign handling, multiplier, and HI/LO registers.

## Test plan
- Reset, then MTHI 0x1234_5678 followed by MTLO 0xDEAD_BEEF → `hi_o`=0x1234_5678 and `lo_o`=0xDEAD_BEEF, each with a 1-cycle `done`; `busy` stays 0.
- MULT 0xFFFF_FFFE × 0x0000_0003 → HI=0xFFFF_FFFF, LO=0xFFFF_FFFA. MULTU with the same operands → HI=0x0000_0002, LO=0xFFFF_FFFA.
- DIV −7 / 2 → after exactly 33 busy cycles, LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU 100 / 7 → LO=14, HI=2.
- DIVU 5 / 0 → no busy, next cycle HI=5, LO=0xFFFF_FFFF. DIV 0x8000_0000 / −1 → LO=0x8000_0000, HI=0.
- Start DIV, assert `cancel` at cycle 10 → `busy` low next cycle, HI/LO unchanged, no `done`. Repeat with `rst` at cycle 10 → all outputs 0.
- `start` pulsed while `busy` → ignored. `start` in the `done` cycle → accepted, second result correct.
